alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Single-entry issue register between RV32I decode and the ALU. Decodes the
//   instruction word into ALU operands, an ALU op code and a destination index,
//   and holds the result in a valid/ready pipeline register.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready decode-side handshake (in_ready is combinational)
//   instr, rd1, rd2   instruction word and register-file read data
//   flush             drop the held bundle and any bundle offered this cycle
//   out_valid/out_ready ALU-side handshake
//   srcA, srcB        registered ALU operands
//   ALUControl        000 add, 001 sub, 010 and, 011 or, 100 slt, 111 pass srcA
//   rd                registered destination register index
//   illegal           registered unsupported-encoding flag
module alu_issue_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] srcA,
  output logic [DATA_W-1:0] srcB,
  output logic [2:0]        ALUControl,
  output logic [4:0]        rd,
  output logic              illegal
);

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  function automatic logic signed [DATA_W-1:0] sext12(input logic [11:0] imm);
    sext12 = {{(DATA_W-12){imm[11]}}, imm};
  endfunction

  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [DATA_W-1:0] w_srcB_p0;
  logic [2:0]        w_alu_p0;
  logic [4:0]        w_rd_p0;
  logic              w_ill_p0;
  logic              w_accept;

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_srcA_p1;
  logic [DATA_W-1:0] r_srcB_p1;
  logic [2:0]        r_alu_p1;
  logic [4:0]        r_rd_p1;
  logic              r_ill_p1;

  assign w_op = instr[6:0];
  assign w_f3 = instr[14:12];
  assign w_f7 = instr[31:25];

  // ---- p0: combinational decode ----
  // Defaults describe the illegal bundle; each legal encoding overrides them.
  always_comb begin
    w_srcB_p0 = rd2;
    w_alu_p0  = ALU_PASS;
    w_rd_p0   = 5'd0;
    w_ill_p0  = 1'b1;
    case (w_op)
      OP_R: begin
        if (w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && w_f3 == 3'b000)) begin
          case (w_f3)
            3'b000: begin w_alu_p0 = w_f7[5] ? ALU_SUB : ALU_ADD; w_ill_p0 = 1'b0; end
            3'b111: begin w_alu_p0 = ALU_AND; w_ill_p0 = 1'b0; end
            3'b110: begin w_alu_p0 = ALU_OR;  w_ill_p0 = 1'b0; end
            3'b010: begin w_alu_p0 = ALU_SLT; w_ill_p0 = 1'b0; end
            default: ;
          endcase
          if (!w_ill_p0) w_rd_p0 = instr[11:7];
        end
      end
      OP_I: begin
        case (w_f3)
          3'b000: begin w_alu_p0 = ALU_ADD; w_ill_p0 = 1'b0; end
          3'b111: begin w_alu_p0 = ALU_AND; w_ill_p0 = 1'b0; end
          3'b110: begin w_alu_p0 = ALU_OR;  w_ill_p0 = 1'b0; end
          3'b010: begin w_alu_p0 = ALU_SLT; w_ill_p0 = 1'b0; end
          default: ;
        endcase
        if (!w_ill_p0) begin
          w_srcB_p0 = sext12(instr[31:20]);
          w_rd_p0   = instr[11:7];
        end
      end
      OP_LOAD: begin
        w_alu_p0  = ALU_ADD;
        w_srcB_p0 = sext12(instr[31:20]);
        w_rd_p0   = instr[11:7];
        w_ill_p0  = 1'b0;
      end
      OP_STORE: begin
        w_alu_p0  = ALU_ADD;
        w_srcB_p0 = sext12({instr[31:25], instr[11:7]});
        w_ill_p0  = 1'b0;
      end
      OP_BR: begin
        w_alu_p0 = ALU_SUB;
        w_ill_p0 = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready = !rst && (!r_vld_p1 || out_ready);
  assign w_accept = in_valid && in_ready;

  // ---- p1: issue register ----
  // Priority: reset, then flush (drops held and incoming bundle), then accept,
  // then consume. Data fields only change on accept so they hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_srcA_p1 <= '0;
      r_srcB_p1 <= '0;
      r_alu_p1  <= ALU_ADD;
      r_rd_p1   <= 5'd0;
      r_ill_p1  <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1  <= 1'b1;
      r_srcA_p1 <= rd1;
      r_srcB_p1 <= w_srcB_p0;
      r_alu_p1  <= w_alu_p0;
      r_rd_p1   <= w_rd_p0;
      r_ill_p1  <= w_ill_p0;
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = r_vld_p1;
  assign srcA       = r_srcA_p1;
  assign srcB       = r_srcB_p1;
  assign ALUControl = r_alu_p1;
  assign rd         = r_rd_p1;
  assign illegal    = r_ill_p1;

endmodule
